// File: rtl/led_blink_arbiter_pkg.sv
// rtl/led_blink_arbiter_pkg.sv - shared state encoding and default timing constants
package led_blink_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ON   = 3'd1,
    ST_OFF  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_TICK_DIV  = 1600000;
  localparam int DEF_ON_TICKS  = 2;
  localparam int DEF_OFF_TICKS = 3;
  localparam int DEF_GAP_TICKS = 10;
  localparam int DEF_HB_TICKS  = 5;

  // Largest phase length, used to size the phase tick counter
  function automatic int max_ticks(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/led_blink_arbiter_tick_gen.sv
// rtl/led_blink_arbiter_tick_gen.sv - restartable prescaler producing a one-cycle tick
module tick_gen
  import led_blink_arbiter_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the last count; clear restarts so the next tick lands TICK_DIV cycles later
  always_comb begin
    tick = (cnt_q == LAST);
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// rtl/led_blink_arbiter.sv - arbitrates blink-code requesters onto one status LED
module led_blink_arbiter
  import led_blink_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int HB_TICKS  = DEF_HB_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] code,
  output logic [N_REQ-1:0]   ack,
  output logic [2:0]         grant,
  output logic               busy,
  output logic               led
);

  localparam int              MAX_T    = max_ticks(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_TICKS);
  localparam int              PH_W     = $clog2(MAX_T + 1);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0] HB_LAST  = PH_W'(HB_TICKS - 1);

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic             hb_q, hb_d;
  logic             tick, clear;
  logic [N_REQ-1:0] cand;
  logic             found;
  logic [2:0]       pick;
  logic [3:0]       pick_code;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  // Lowest-index unmasked requester wins; its nibble is captured alongside
  always_comb begin
    cand      = req & ~mask_q;
    found     = 1'b0;
    pick      = 3'd0;
    pick_code = 4'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found     = 1'b1;
        pick      = 3'(i);
        pick_code = code[4*i +: 4];
      end
    end
  end

  // Next-state, phase timing, heartbeat, and ack/mask generation
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    mask_d  = '0;
    hb_d    = hb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (ph_q == HB_LAST) begin
            ph_d = '0;
            hb_d = ~hb_q;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
        if (found) begin
          grant_d = pick;
          cnt_d   = pick_code;
          state_d = (pick_code == 4'd0) ? ST_DONE : ST_ON;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (ph_q == ON_LAST) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? ST_GAP : ST_OFF;
          end else begin
            ph_d = ph_q + PH_W'(1);
          end
        end
      end
      ST_OFF: begin
        if (tick) begin
          if (ph_q == OFF_LAST) state_d = ST_ON;
          else                  ph_d    = ph_q + PH_W'(1);
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (ph_q == GAP_LAST) state_d = ST_DONE;
          else                  ph_d    = ph_q + PH_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q == 3'(i)) begin
            ack_d[i]  = 1'b1;
            mask_d[i] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every state entry restarts prescaler, phase counter and heartbeat phase
    clear = (state_d != state_q);
    if (clear) begin
      ph_d = '0;
      hb_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      mask_q  <= '0;
      hb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      mask_q  <= mask_d;
      hb_q    <= hb_d;
    end
  end

  // Output decode
  always_comb begin
    ack   = ack_q;
    grant = grant_q;
    busy  = (state_q != ST_IDLE);
    led   = (state_q == ST_ON) || ((state_q == ST_IDLE) && hb_q);
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb/tb_led_blink_arbiter.sv - directed self-checking bench for led_blink_arbiter
module tb_led_blink_arbiter;

  localparam int N_REQ = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] code;
  logic [N_REQ-1:0]   ack;
  logic [2:0]         grant;
  logic               busy;
  logic               led;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_blink_arbiter #(
    .N_REQ    (N_REQ),
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(2),
    .GAP_TICKS(4),
    .HB_TICKS (5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .code (code),
    .ack  (ack),
    .grant(grant),
    .busy (busy),
    .led  (led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_led(input logic level, output int len);
    len = 0;
    while (led === level && len < 400) begin
      len++;
      step();
    end
  endtask

  task automatic run_busy(output int len, output int led_hi);
    len    = 0;
    led_hi = 0;
    while (busy === 1'b1 && len < 400) begin
      len++;
      if (led === 1'b1) led_hi++;
      step();
    end
  endtask

  initial begin
    int len;
    int hi;
    int ack_seen;

    rst  = 1'b1;
    req  = '0;
    code = '0;
    repeat (3) step();
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_grant", grant, 0);
    rst = 1'b0;

    // Heartbeat: 20 cycles low, 20 high, 20 low
    run_led(1'b0, len); check("hb_low0", len, 20);
    run_led(1'b1, len); check("hb_high", len, 20);
    run_led(1'b0, len); check("hb_low1", len, 20);
    check("hb_busy", busy, 0);
    check("hb_ack", ack, 0);

    // Requester 1, code 3; code change after grant is ignored
    code = 16'h0030;
    req  = 4'b0010;
    step();
    check("c3_busy", busy, 1);
    check("c3_grant", grant, 1);
    check("c3_led", led, 1);
    code = 16'h0050;
    run_led(1'b1, len); check("c3_on0", len, 8);
    run_led(1'b0, len); check("c3_off0", len, 8);
    run_led(1'b1, len); check("c3_on1", len, 8);
    run_led(1'b0, len); check("c3_off1", len, 8);
    run_led(1'b1, len); check("c3_on2", len, 8);
    run_busy(len, hi);
    check("c3_gap_done_len", len, 17);
    check("c3_gap_led", hi, 0);
    check("c3_ack", ack, 4'b0010);
    check("c3_idle_led", led, 0);
    req = '0;
    step();
    check("c3_ack_once", ack, 0);
    check("c3_no_regrant", busy, 0);

    // Requester 2, code 0: DONE for one cycle, then ack
    code = 16'h0000;
    req  = 4'b0100;
    step();
    check("c0_busy", busy, 1);
    check("c0_grant", grant, 2);
    check("c0_ack_early", ack, 0);
    check("c0_led", led, 0);
    step();
    check("c0_busy_end", busy, 0);
    check("c0_ack", ack, 4'b0100);
    req = '0;
    step();
    check("c0_ack_once", ack, 0);

    // Requesters 0 and 2 together: 0 first, 2 granted out of the ack cycle
    code = 16'h0201;
    req  = 4'b0101;
    step();
    check("pr_grant0", grant, 0);
    check("pr_busy0", busy, 1);
    run_busy(len, hi);
    check("pr_len0", len, 25);
    check("pr_hi0", hi, 8);
    check("pr_ack0", ack, 4'b0001);
    req = 4'b0100;
    step();
    check("pr_grant2", grant, 2);
    check("pr_busy2", busy, 1);
    check("pr_no_overlap", ack, 0);
    run_busy(len, hi);
    check("pr_len2", len, 41);
    check("pr_hi2", hi, 16);
    check("pr_ack2", ack, 4'b0100);
    req = '0;
    step();

    // Reset in the middle of an OFF phase
    code = 16'h0020;
    req  = 4'b0010;
    step();
    run_led(1'b1, len); check("rs_on", len, 8);
    repeat (3) step();
    check("rs_in_off", busy, 1);
    rst = 1'b1;
    step();
    check("rs_led", led, 0);
    check("rs_busy", busy, 0);
    check("rs_ack", ack, 0);
    check("rs_grant", grant, 0);
    rst = 1'b0;
    req = '0;
    ack_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (ack !== '0 || busy !== 1'b0) ack_seen++;
    end
    check("rs_quiet", ack_seen, 0);

    // Requester 3 held across ack: masked for one cycle, then served again
    code = 16'h1000;
    req  = 4'b1000;
    step();
    check("hd_grant", grant, 3);
    run_busy(len, hi);
    check("hd_len", len, 25);
    check("hd_ack", ack, 4'b1000);
    step();
    check("hd_masked", busy, 0);
    check("hd_ack_once", ack, 0);
    step();
    check("hd_regrant_busy", busy, 1);
    check("hd_regrant", grant, 3);
    req = '0;
    run_busy(len, hi);
    check("hd_len2", len, 25);
    check("hd_ack2", ack, 4'b1000);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_blink_arbiter.md
LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of blink-code requesters (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 1600000: clk cycles per tick (100 ms at 16 MHz).
REQ-003 SHALL have parameter ON_TICKS, default 2: ticks LED is lit per blink.
REQ-004 SHALL have parameter OFF_TICKS, default 3: ticks LED is dark between blinks.
REQ-005 SHALL have parameter GAP_TICKS, default 10: ticks LED is dark after the last blink.
REQ-006 SHALL have parameter HB_TICKS, default 5: ticks per heartbeat toggle when idle.
REQ-007 SHALL have port clk, input, 1: system clock (16 MHz board oscillator).
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port req, input, N_REQ: per-requester blink request, level, held until ack.
REQ-010 SHALL have port code, input, 4*N_REQ: nibble i is requester i's blink count (0..15).
REQ-011 SHALL have port ack, output, N_REQ: one-cycle completion pulse per requester.
REQ-012 SHALL have port grant, output, 3: index of the requester being served.
REQ-013 SHALL have port busy, output, 1: high while a blink code is being shown.
REQ-014 SHALL have port led, output, 1: drives the board LED, active-high.

Function
REQ-015 SHALL implement states IDLE, ON, OFF, GAP, DONE.
REQ-016 In IDLE, led SHALL toggle every HB_TICKS ticks (heartbeat), starting at 0 on each IDLE entry.
REQ-017 In IDLE with any unmasked req bit high, SHALL grant the lowest index, latch its code nibble into a blink counter, and set busy on the next cycle.
REQ-018 A latched code of 0 SHALL go IDLE->DONE directly (no blinks); nonzero SHALL go IDLE->ON.
REQ-019 ON SHALL last exactly ON_TICKS*TICK_DIV cycles with led=1, then decrement the blink counter.
REQ-020 After ON, SHALL go to OFF if the counter is nonzero, else GAP.
REQ-021 OFF SHALL last exactly OFF_TICKS*TICK_DIV cycles with led=0, then return to ON.
REQ-022 GAP SHALL last exactly GAP_TICKS*TICK_DIV cycles with led=0, then enter DONE.
REQ-023 DONE SHALL last one cycle and then enter IDLE.
REQ-024 ack[grant] SHALL be registered, high for exactly the first IDLE cycle after DONE; all other ack bits SHALL stay 0.
REQ-025 In that first IDLE cycle, arbitration SHALL mask the just-acked requester, so a req dropped one cycle after ack is not served twice.
REQ-026 Arbitration SHALL be non-preemptive: req and code changes during ON/OFF/GAP/DONE SHALL be ignored.
REQ-027 A req deasserted mid-code SHALL NOT abort the code; ack SHALL still be issued.
REQ-028 The tick prescaler SHALL restart at 0 on every state entry, making phase durations exact.
REQ-029 The phase tick counter SHALL be sized for max(ON,OFF,GAP,HB)_TICKS and SHALL NOT wrap within a phase.
REQ-030 busy SHALL be 1 in ON, OFF, GAP and DONE, and 0 in IDLE.
REQ-031 grant SHALL hold the last served index in IDLE.

Reset
REQ-032 On rst: state=IDLE, led=0, busy=0, ack=0, grant=0, prescaler, counters and mask cleared.
REQ-033 rst asserted mid-code SHALL abort immediately with no ack for the aborted requester.
REQ-034 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-035 A shared package SHALL hold the state encoding and the default TICK_DIV and phase-tick constants.
REQ-036 The prescaler SHALL be one sub-module, tick_gen, with inputs clk, rst and clear, and output tick (one-cycle pulse every TICK_DIV cycles after clear).

Verification (TICK_DIV=4, ON=2, OFF=2, GAP=4, HB=5)
REQ-037 Idle, no req: led toggles every 20 cycles, busy=0, ack=0.
REQ-038 req[1]=1, code1=3: led high 8 / low 8 / high 8 / low 8 / high 8, then low 16; ack[1] pulses once; grant=1.
REQ-039 req[0] and req[2] raised in the same cycle: requester 0 is served first and requester 2 is granted right after ack[0]; no overlap.
REQ-040 code2=0, req[2]=1: no blinks; busy high 1 cycle; ack[2] pulses 2 cycles after grant.
REQ-041 rst pulsed mid-OFF: next cycle led=0, busy=0, state IDLE, no ack pulse.
REQ-042 req[3] held high across ack: requester 3 is not re-granted in the ack cycle, and is re-granted in the following cycle.
